// File: rtl/hazard_result_tracker_if.sv
// ---------------------------------------------------------------------------
// hazard_result_tracker_if
// Bundles the decode-side inputs and the E/M/W forwarding outputs of the
// hazard_result_tracker so that the forwarding producer can be wired as a
// single port.
//
// Signals:
//   D_A3, D_Tnew, D_link      decode-stage destination, Tnew and link value
//   D_rs, D_rt                decode-stage source registers
//   D_Tuse_rs, D_Tuse_rt      Tuse per source (3 = operand not used)
//   E_result, M_result        ALU result in E, memory read data in M
//   flush                     kill of the D instruction (bubble into E)
//   stall                     hold of PC and D register
//   {E,M,W}_{A3,Tnew,WD}      per-stage forwarding producer values
//   stall_cnt                 stall-cycle counter (HAZARD_STALL_COUNT_EN only)
//
// Modports:
//   master  the surrounding core / testbench (drives decode inputs)
//   slave   the hazard_result_tracker itself
//
// Optional feature macro: HAZARD_STALL_COUNT_EN
// ---------------------------------------------------------------------------
interface hazard_result_tracker_if #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int TW = 2
);
  logic [AW-1:0] D_A3;
  logic [TW-1:0] D_Tnew;
  logic [DW-1:0] D_link;
  logic [AW-1:0] D_rs;
  logic [AW-1:0] D_rt;
  logic [TW-1:0] D_Tuse_rs;
  logic [TW-1:0] D_Tuse_rt;
  logic [DW-1:0] E_result;
  logic [DW-1:0] M_result;
  logic          flush;
  logic          stall;
  logic [AW-1:0] E_A3;
  logic [TW-1:0] E_Tnew;
  logic [DW-1:0] E_WD;
  logic [AW-1:0] M_A3;
  logic [TW-1:0] M_Tnew;
  logic [DW-1:0] M_WD;
  logic [AW-1:0] W_A3;
  logic [TW-1:0] W_Tnew;
  logic [DW-1:0] W_WD;
`ifdef HAZARD_STALL_COUNT_EN
  logic [DW-1:0] stall_cnt;
`endif

  modport master (
    output D_A3, D_Tnew, D_link, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt,
           E_result, M_result, flush,
    input  stall, E_A3, E_Tnew, E_WD, M_A3, M_Tnew, M_WD, W_A3, W_Tnew, W_WD
`ifdef HAZARD_STALL_COUNT_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  D_A3, D_Tnew, D_link, D_rs, D_rt, D_Tuse_rs, D_Tuse_rt,
           E_result, M_result, flush,
    output stall, E_A3, E_Tnew, E_WD, M_A3, M_Tnew, M_WD, W_A3, W_Tnew, W_WD
`ifdef HAZARD_STALL_COUNT_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/hazard_result_tracker.sv
// ---------------------------------------------------------------------------
// hazard_result_tracker
// Producer side of the forwarding network of a 5-stage MIPS32 core. Tracks
// the destination register (A3), cycles-until-ready (Tnew) and write data
// (WD) of the instructions in E, M and W, and raises the D-stage stall when
// a source operand is needed (Tuse) before an in-flight producer has it.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    hazard_result_tracker_if.slave (decode inputs, stage outputs,
//          stall, optional stall_cnt)
//
// Internal stage naming: _p0 = E, _p1 = M, _p2 = W.
//
// Optional feature macro: HAZARD_STALL_COUNT_EN
//   Adds bus.stall_cnt, a wrapping DW-bit count of cycles with stall==1.
// ---------------------------------------------------------------------------
module hazard_result_tracker #(
  parameter int AW = 5,
  parameter int DW = 32,
  parameter int TW = 2
) (
  input logic                   clk,
  input logic                   reset,
  hazard_result_tracker_if.slave bus
);

  // Tnew counts down by one per stage and stays at 0 once the value exists.
  function automatic logic [TW-1:0] f_tnew_dec(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - TW'(1);
  endfunction

  // One source against one producer. $0 never matches; Tuse==3 can never
  // be below a real Tnew, so unused operands drop out naturally.
  function automatic logic f_hit(input logic [AW-1:0] src,
                                 input logic [TW-1:0] tuse,
                                 input logic [AW-1:0] a3,
                                 input logic [TW-1:0] tnew);
    return (src != '0) && (a3 == src) && (tuse < tnew);
  endfunction

  logic [AW-1:0] r_a3_p0;
  logic [TW-1:0] r_tnew_p0;
  logic [DW-1:0] r_link_p0;
  logic [AW-1:0] r_a3_p1;
  logic [TW-1:0] r_tnew_p1;
  logic [DW-1:0] r_wd_p1;
  logic [AW-1:0] r_a3_p2;
  logic [TW-1:0] r_tnew_p2;
  logic [DW-1:0] r_wd_p2;
  logic          w_stall;
  logic          w_bubble;

  always_comb begin
    w_stall = 1'b0;
    if (f_hit(bus.D_rs, bus.D_Tuse_rs, r_a3_p0, r_tnew_p0) ||
        f_hit(bus.D_rs, bus.D_Tuse_rs, r_a3_p1, r_tnew_p1) ||
        f_hit(bus.D_rt, bus.D_Tuse_rt, r_a3_p0, r_tnew_p0) ||
        f_hit(bus.D_rt, bus.D_Tuse_rt, r_a3_p1, r_tnew_p1)) begin
      w_stall = 1'b1;
    end
  end

  assign w_bubble = w_stall | bus.flush;

  // ---- D -> E (p0) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3_p0   <= '0;
      r_tnew_p0 <= '0;
      r_link_p0 <= '0;
    end else if (w_bubble) begin
      r_a3_p0   <= '0;
      r_tnew_p0 <= '0;
      r_link_p0 <= '0;
    end else begin
      r_a3_p0   <= bus.D_A3;
      // A non-writing instruction is tracked as already ready.
      r_tnew_p0 <= (bus.D_A3 == '0) ? '0 : bus.D_Tnew;
      r_link_p0 <= bus.D_link;
    end
  end

  // ---- E (p0) -> M (p1), never held by stall ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3_p1   <= '0;
      r_tnew_p1 <= '0;
      r_wd_p1   <= '0;
    end else begin
      r_a3_p1   <= r_a3_p0;
      r_tnew_p1 <= f_tnew_dec(r_tnew_p0);
      r_wd_p1   <= (r_tnew_p0 == '0) ? r_link_p0 : bus.E_result;
    end
  end

  // ---- M (p1) -> W (p2) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a3_p2   <= '0;
      r_tnew_p2 <= '0;
      r_wd_p2   <= '0;
    end else begin
      r_a3_p2   <= r_a3_p1;
      r_tnew_p2 <= f_tnew_dec(r_tnew_p1);
      r_wd_p2   <= (r_tnew_p1 == '0) ? r_wd_p1 : bus.M_result;
    end
  end

`ifdef HAZARD_STALL_COUNT_EN
  logic [DW-1:0] r_stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall) begin
      r_stall_cnt <= r_stall_cnt + DW'(1);
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`endif

  assign bus.stall  = w_stall;
  assign bus.E_A3   = r_a3_p0;
  assign bus.E_Tnew = r_tnew_p0;
  assign bus.E_WD   = r_link_p0;
  assign bus.M_A3   = r_a3_p1;
  assign bus.M_Tnew = r_tnew_p1;
  assign bus.M_WD   = r_wd_p1;
  assign bus.W_A3   = r_a3_p2;
  assign bus.W_Tnew = r_tnew_p2;
  assign bus.W_WD   = r_wd_p2;

endmodule

// File: tb/tb_hazard_result_tracker.sv
module tb_hazard_result_tracker;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  hazard_result_tracker_if #(.AW(5), .DW(32), .TW(2)) hif ();

  hazard_result_tracker #(.AW(5), .DW(32), .TW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a3;
    logic [1:0]  tnew;
    logic [31:0] link;
    logic [4:0]  rs;
    logic [1:0]  tu_rs;
    logic [4:0]  rt;
    logic [1:0]  tu_rt;
    logic [31:0] eres;
    logic [31:0] mres;
    logic        flush;
    logic        x_stall;
    logic [4:0]  x_ea3;
    logic [1:0]  x_etn;
    logic [31:0] x_ewd;
    logic [4:0]  x_ma3;
    logic [1:0]  x_mtn;
    logic [31:0] x_mwd;
    logic [4:0]  x_wa3;
    logic [1:0]  x_wtn;
    logic [31:0] x_wwd;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
      input logic [4:0] a3, input logic [1:0] tnew, input logic [31:0] link,
      input logic [4:0] rs, input logic [1:0] tu_rs,
      input logic [4:0] rt, input logic [1:0] tu_rt,
      input logic [31:0] eres, input logic [31:0] mres, input logic flush,
      input logic xs,
      input logic [4:0] ea3, input logic [1:0] etn, input logic [31:0] ewd,
      input logic [4:0] ma3, input logic [1:0] mtn, input logic [31:0] mwd,
      input logic [4:0] wa3, input logic [1:0] wtn, input logic [31:0] wwd);
    vec_t v;
    v.a3 = a3; v.tnew = tnew; v.link = link; v.rs = rs; v.tu_rs = tu_rs;
    v.rt = rt; v.tu_rt = tu_rt; v.eres = eres; v.mres = mres; v.flush = flush;
    v.x_stall = xs; v.x_ea3 = ea3; v.x_etn = etn; v.x_ewd = ewd;
    v.x_ma3 = ma3; v.x_mtn = mtn; v.x_mwd = mwd;
    v.x_wa3 = wa3; v.x_wtn = wtn; v.x_wwd = wwd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_stage(input string tag,
      input logic [4:0] ea3, input logic [1:0] etn, input logic [31:0] ewd,
      input logic [4:0] ma3, input logic [1:0] mtn, input logic [31:0] mwd,
      input logic [4:0] wa3, input logic [1:0] wtn, input logic [31:0] wwd);
    chk({tag, ".E_A3"},   32'(hif.E_A3),   32'(ea3));
    chk({tag, ".E_Tnew"}, 32'(hif.E_Tnew), 32'(etn));
    chk({tag, ".E_WD"},   hif.E_WD,        ewd);
    chk({tag, ".M_A3"},   32'(hif.M_A3),   32'(ma3));
    chk({tag, ".M_Tnew"}, 32'(hif.M_Tnew), 32'(mtn));
    chk({tag, ".M_WD"},   hif.M_WD,        mwd);
    chk({tag, ".W_A3"},   32'(hif.W_A3),   32'(wa3));
    chk({tag, ".W_Tnew"}, 32'(hif.W_Tnew), 32'(wtn));
    chk({tag, ".W_WD"},   hif.W_WD,        wwd);
  endtask

  task automatic drive(input vec_t v);
    hif.D_A3      = v.a3;
    hif.D_Tnew    = v.tnew;
    hif.D_link    = v.link;
    hif.D_rs      = v.rs;
    hif.D_Tuse_rs = v.tu_rs;
    hif.D_rt      = v.rt;
    hif.D_Tuse_rt = v.tu_rt;
    hif.E_result  = v.eres;
    hif.M_result  = v.mres;
    hif.flush     = v.flush;
  endtask

  task automatic drive_random();
    hif.D_A3      = 5'($urandom);
    hif.D_Tnew    = 2'($urandom);
    hif.D_link    = $urandom;
    hif.D_rs      = 5'($urandom);
    hif.D_Tuse_rs = 2'($urandom);
    hif.D_rt      = 5'($urandom);
    hif.D_Tuse_rt = 2'($urandom);
    hif.E_result  = $urandom;
    hif.M_result  = $urandom;
    hif.flush     = 1'($urandom);
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;

    // Columns: D_A3 Tnew link | rs Tuse_rs rt Tuse_rt | E_res M_res flush |
    //          stall | E a3/tn/wd | M a3/tn/wd | W a3/tn/wd (after the edge)
    tbl[0]  = mk(8, 1, 'h100,  0,3, 0,3, 'h0,    'h0,    0, 0,  8,1,'h100,  0,0,'h0,    0,0,'h0);
    tbl[1]  = mk(9, 1, 'h200,  0,3, 0,3, 'hAAAA, 'h0,    0, 0,  9,1,'h200,  8,0,'hAAAA, 0,0,'h0);
    tbl[2]  = mk(0, 2, 'h300,  0,3, 0,3, 'h1234, 'h5555, 0, 0,  0,0,'h300,  9,0,'h1234, 8,0,'hAAAA);
    tbl[3]  = mk(31,0, 'h3008, 0,0, 0,3, 'h9999, 'h7777, 0, 0, 31,0,'h3008, 0,0,'h300,  9,0,'h1234);
    tbl[4]  = mk(5, 2, 'h400, 31,0, 0,3, 'hDEAD, 'h0,    0, 0,  5,2,'h400, 31,0,'h3008, 0,0,'h300);
    tbl[5]  = mk(6, 1, 'h500,  5,0, 0,3, 'h40,   'hBEEF, 0, 1,  0,0,'h0,    5,1,'h40,  31,0,'h3008);
    tbl[6]  = mk(6, 1, 'h500,  5,0, 0,3, 'h1111, 'hCAFE, 0, 1,  0,0,'h0,    0,0,'h0,    5,0,'hCAFE);
    tbl[7]  = mk(6, 1, 'h500,  5,0, 0,3, 'h1111, 'h0,    0, 0,  6,1,'h500,  0,0,'h0,    0,0,'h0);
    tbl[8]  = mk(7, 2, 'h600,  0,3, 0,3, 'h2222, 'h0,    0, 0,  7,2,'h600,  6,0,'h2222, 0,0,'h0);
    tbl[9]  = mk(10,1, 'h700,  0,3, 7,1, 'h80,   'h3333, 0, 1,  0,0,'h0,    7,1,'h80,   6,0,'h2222);
    tbl[10] = mk(10,1, 'h700,  0,3, 7,1, 'h4444, 'hF00D, 0, 0, 10,1,'h700,  0,0,'h0,    7,0,'hF00D);
    tbl[11] = mk(11,2, 'h800,  0,3, 0,3, 'h5555, 'h0,    0, 0, 11,2,'h800, 10,0,'h5555, 0,0,'h0);
    tbl[12] = mk(12,1, 'h900, 11,0, 0,3, 'h60,   'h0,    1, 1,  0,0,'h0,   11,1,'h60,  10,0,'h5555);
    tbl[13] = mk(12,1, 'h900, 11,0, 0,3, 'h77,   'hABCD, 1, 1,  0,0,'h0,    0,0,'h0,   11,0,'hABCD);
    tbl[14] = mk(12,1, 'h900, 11,0, 0,3, 'h0,    'h0,    0, 0, 12,1,'h900,  0,0,'h0,    0,0,'h0);
    tbl[15] = mk(13,1, 'hA00,  0,3, 0,3, 'h88,   'h0,    1, 0,  0,0,'h0,   12,0,'h88,   0,0,'h0);

    // Reset held with random inputs: everything must stay cleared.
    reset = 1'b0;
    drive_random();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_random();
      #1;
      chk("rst.stall", 32'(hif.stall), 32'd0);
    end
    chk_stage("rst", 0,0,'h0, 0,0,'h0, 0,0,'h0);
`ifdef HAZARD_STALL_COUNT_EN
    chk("rst.stall_cnt", hif.stall_cnt, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d.stall", i), 32'(hif.stall), 32'(tbl[i].x_stall));
      @(posedge clk);
      #1;
      chk_stage($sformatf("row%0d", i),
                tbl[i].x_ea3, tbl[i].x_etn, tbl[i].x_ewd,
                tbl[i].x_ma3, tbl[i].x_mtn, tbl[i].x_mwd,
                tbl[i].x_wa3, tbl[i].x_wtn, tbl[i].x_wwd);
    end
`ifdef HAZARD_STALL_COUNT_EN
    chk("tbl.stall_cnt", hif.stall_cnt, 32'd5);
`endif

    // Asynchronous reset mid-operation: clears without waiting for an edge.
    @(negedge clk);
    v = mk(11, 2, 'hB00, 0,3, 0,3, 'h99, 'h98, 0, 0, 0,0,0, 0,0,0, 0,0,0);
    drive(v);
    @(posedge clk);
    #1;
    chk("pre_rst.E_A3", 32'(hif.E_A3), 32'd11);
    #2;
    hif.D_rs      = 5'd11;
    hif.D_Tuse_rs = 2'd0;
    #1;
    chk("pre_rst.stall", 32'(hif.stall), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst.stall", 32'(hif.stall), 32'd0);
    chk_stage("arst", 0,0,'h0, 0,0,'h0, 0,0,'h0);
`ifdef HAZARD_STALL_COUNT_EN
    chk("arst.stall_cnt", hif.stall_cnt, 32'd0);
`endif

    // Release: first edge loads E from D normally.
    @(negedge clk);
    reset = 1'b1;
    v = mk(20, 2, 'h1000, 0,3, 0,3, 'h0, 'h0, 0, 0, 0,0,0, 0,0,0, 0,0,0);
    drive(v);
    @(posedge clk);
    #1;
    chk_stage("rel", 20,2,'h1000, 0,0,'h0, 0,0,'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
